kronos_hcu: RTL

- Hazard control unit for the Kronos ID stage: a register scoreboard that tracks in-flight writes to each of x1..x31.
- It gates the ID-to-EX handshake (pipe_out) whenever a decoded instruction reads a register whose write-back is still pending.
- Sits beside the decoder. Issue events come from the IDEX handshake. Retire events come from the regwr write-back port.
- It also sequences a fixed post-flush drain window.

---
 rtl/kronos_hcu.sv | 94 +++++++++
 1 files changed

// File: rtl/kronos_hcu.sv
// kronos_hcu: register scoreboard that gates ID->EX issue on RAW/WAW-overflow hazards and sequences a post-flush drain
module kronos_hcu #(
  parameter int CNT_W        = 2,
  parameter int FLUSH_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic        id_vld,
  input  logic [4:0]  id_rs1,
  input  logic        id_rs1_read,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs2_read,
  input  logic [4:0]  id_rd,
  input  logic        id_rd_write,
  input  logic        ex_rdy,
  output logic        issue_vld,
  output logic        issue_rdy,
  input  logic        regwr_en,
  input  logic [4:0]  regwr_sel,
  input  logic        flush,
  output logic [31:0] pending,
  output logic [15:0] stall_count,
  output logic        sb_err
);
  typedef enum logic {RUN, DRAIN} state_t;
  state_t           state_q, state_d;
  logic [3:0]       drain_q, drain_d;
  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic             mask_q, mask_d, sb_err_q, sb_err_d;
  logic [15:0]      stall_q, stall_d;
  logic             hz, block, fire, inc_en, dec_en, err_hit;
  logic [31:0]      inc_vec, dec_vec;
  // hazard detection, issue gating and per-register inc/dec requests
  always_comb begin
    hz = (id_rs1_read && id_rs1 != 5'd0 && cnt_q[id_rs1] != '0)
       | (id_rs2_read && id_rs2 != 5'd0 && cnt_q[id_rs2] != '0)
       | (id_rd_write && id_rd != 5'd0 && cnt_q[id_rd] == '1);
    block     = hz | (state_q == DRAIN) | flush;
    issue_vld = rstz & id_vld & ~block;
    issue_rdy = rstz & ex_rdy & ~block;
    fire      = issue_vld & ex_rdy;
    inc_en    = fire & id_rd_write & (id_rd != 5'd0);
    dec_en    = regwr_en & (regwr_sel != 5'd0);
    inc_vec   = inc_en ? (32'd1 << id_rd) : 32'd0;
    dec_vec   = dec_en ? (32'd1 << regwr_sel) : 32'd0;
    err_hit   = dec_en & ~inc_vec[regwr_sel] & (cnt_q[regwr_sel] == '0) & ~mask_q & ~flush;
    sb_err_d  = sb_err_q | err_hit;
    mask_d    = flush | (mask_q & ~fire);
    stall_d   = (id_vld && block && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  end
  // counter next state: flush clears, inc/dec of the same register cancel, underflow holds at zero
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      cnt_d[i]   = flush ? '0
                 : (inc_vec[i] & ~dec_vec[i]) ? cnt_q[i] + 1'b1
                 : (dec_vec[i] & ~inc_vec[i] & (cnt_q[i] != '0)) ? cnt_q[i] - 1'b1
                 : cnt_q[i];
      pending[i] = cnt_q[i] != '0;
    end
  end
  // drain sequencer: flush (re)loads the window, DRAIN counts down to zero then resumes RUN
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    if (flush) begin
      state_d = DRAIN;
      drain_d = 4'(FLUSH_CYCLES - 1);
    end else if (state_q == DRAIN) begin
      state_d = (drain_q == 4'd0) ? RUN : DRAIN;
      drain_d = (drain_q == 4'd0) ? drain_q : drain_q - 4'd1;
    end
  end
  // state registers
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q  <= RUN;
      drain_q  <= 4'd0;
      mask_q   <= 1'b0;
      sb_err_q <= 1'b0;
      stall_q  <= 16'd0;
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      mask_q   <= mask_d;
      sb_err_q <= sb_err_d;
      stall_q  <= stall_d;
      for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
    end
  end
  assign sb_err      = sb_err_q;
  assign stall_count = stall_q;
endmodule
